fifo_wr_arbiter: RTL and testbench

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 118 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that bursts up to BURST_MAX beats from one requester
// at a time into a downstream FIFO, stalling on fifo_full.
module fifo_wr_arbiter #(
    parameter int DWIDTH    = 8,
    parameter int NREQ      = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DWIDTH-1:0]    req_data,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DWIDTH-1:0]         fifo_wdata,
    output logic [$clog2(NREQ)-1:0]   fifo_wtag,
    output logic                      busy
);

    localparam int TW = $clog2(NREQ);

    typedef enum logic {ARB, GRANT} state_t;

    state_t          r_state;
    logic [TW-1:0]   r_grant_id;
    logic [TW-1:0]   r_last_id;
    logic [3:0]      r_beat_cnt;

    state_t          w_state_nxt;
    logic [TW-1:0]   w_grant_nxt;
    logic [TW-1:0]   w_last_nxt;
    logic [3:0]      w_cnt_nxt;
    logic [3:0]      w_cnt_inc;
    logic [TW-1:0]   w_pick;
    logic [TW-1:0]   w_idx;
    logic            w_found;
    logic            w_gvalid;
    logic            w_xfer;
    logic [DWIDTH-1:0] w_gdata;

    assign w_gvalid  = req_valid[r_grant_id];
    assign w_xfer    = (r_state == GRANT) && w_gvalid && !fifo_full;
    assign w_gdata   = req_data[int'(r_grant_id) * DWIDTH +: DWIDTH];
    assign w_cnt_inc = r_beat_cnt + 4'd1;

    // Scan starts just past the last winner; k == NREQ wraps back onto last_id itself.
    always_comb begin
        w_pick  = r_last_id;
        w_idx   = r_last_id;
        w_found = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            w_idx = r_last_id + TW'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_pick  = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ARB;
            r_grant_id <= '0;
            r_last_id  <= TW'(NREQ - 1);
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_grant_id <= w_grant_nxt;
            r_last_id  <= w_last_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant_id;
        w_last_nxt  = r_last_id;
        w_cnt_nxt   = r_beat_cnt;
        case (r_state)
            ARB: begin
                if (|req_valid) begin
                    w_state_nxt = GRANT;
                    w_grant_nxt = w_pick;
                    w_cnt_nxt   = '0;
                end
            end
            GRANT: begin
                if (!w_gvalid) begin
                    w_state_nxt = ARB;
                    w_last_nxt  = r_grant_id;
                end else if (w_xfer) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == 4'(BURST_MAX)) begin
                        w_state_nxt = ARB;
                        w_last_nxt  = r_grant_id;
                    end
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        fifo_wr    = 1'b0;
        fifo_wdata = '0;
        fifo_wtag  = '0;
        busy       = 1'b0;
        if (r_state == GRANT) begin
            busy                  = 1'b1;
            req_ready[r_grant_id] = !fifo_full;
            fifo_wr               = w_xfer;
            fifo_wdata            = w_gdata;
            fifo_wtag             = r_grant_id;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: scenarios push expected FIFO writes,
// a negedge monitor pops them, and each scenario checks per-cycle control.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_full;
    logic        fifo_wr;
    logic [7:0]  fifo_wdata;
    logic [1:0]  fifo_wtag;
    logic        busy;

    int vectors;
    int errors;
    logic [7:0] rdat [4];
    logic [9:0] sb_q [$];

    fifo_wr_arbiter #(.DWIDTH(8), .NREQ(4), .BURST_MAX(4)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
        .fifo_wdata(fifo_wdata), .fifo_wtag(fifo_wtag), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: every strobe must match the oldest expected beat.
    always @(negedge clk) begin
        logic [9:0] exp_item;
        if (fifo_wr === 1'b1) begin
            vectors++;
            if (fifo_full !== 1'b0) begin
                errors++;
                $display("FAIL wr_while_full: fifo_full=%b with fifo_wr=1, required fifo_full=0", fifo_full);
            end
            vectors++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: tag=%0d data=%h, required no write", fifo_wtag, fifo_wdata);
            end else begin
                exp_item = sb_q.pop_front();
                if ({fifo_wtag, fifo_wdata} !== exp_item) begin
                    errors++;
                    $display("FAIL sb_beat: tag=%0d data=%h, required tag=%0d data=%h",
                             fifo_wtag, fifo_wdata, exp_item[9:8], exp_item[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [3:0] v, input logic f, input logic r);
        req_valid = v;
        fifo_full = f;
        rst       = r;
        req_data  = {rdat[3], rdat[2], rdat[1], rdat[0]};
    endtask

    task automatic do_reset();
        tick(); apply(4'b0000, 1'b0, 1'b1);
        tick(); apply(4'b0000, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rdat = '{8'h0F, 8'h11, 8'h22, 8'h33};
        tick(); apply(4'b1111, 1'b0, 1'b1);
        tick(); apply(4'b1111, 1'b0, 1'b1);
        #2;
        vectors++;
        if ({busy, fifo_wr, req_ready, fifo_wtag, fifo_wdata} !== 16'h0) begin
            errors++;
            $display("FAIL reset_hold: busy=%b wr=%b rdy=%b tag=%0d data=%h, required all 0",
                     busy, fifo_wr, req_ready, fifo_wtag, fifo_wdata);
        end
        tick(); apply(4'b0000, 1'b0, 1'b0);
        #2;
        vectors++;
        if ({busy, fifo_wr, req_ready, fifo_wtag, fifo_wdata} !== 16'h0) begin
            errors++;
            $display("FAIL reset_after: busy=%b wr=%b rdy=%b tag=%0d data=%h, required all 0",
                     busy, fifo_wr, req_ready, fifo_wtag, fifo_wdata);
        end
        tick(); apply(4'b0000, 1'b0, 1'b0);
        #2;
        vectors++;
        if ({busy, fifo_wr, req_ready} !== 6'h0) begin
            errors++;
            $display("FAIL idle_arb: busy=%b wr=%b rdy=%b, required all 0", busy, fifo_wr, req_ready);
        end
    endtask

    task automatic test_single_burst();
        logic eb, ewr;
        logic [3:0] erdy;
        rdat = '{8'h5C, 8'h11, 8'h22, 8'h33};
        do_reset();
        for (int b = 0; b < 8; b++) sb_q.push_back({2'd0, 8'h5C});
        for (int i = 0; i < 11; i++) begin
            tick(); apply((i < 10) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
            eb  = (i != 0) && (i != 5) && (i != 10);
            ewr = eb;
            erdy = eb ? 4'b0001 : 4'b0000;
            #2;
            vectors++;
            if (fifo_wr !== ewr || busy !== eb) begin
                errors++;
                $display("FAIL single_ctl cyc%0d: wr=%b busy=%b, required wr=%b busy=%b", i, fifo_wr, busy, ewr, eb);
            end
            vectors++;
            if ({req_ready, fifo_wtag, fifo_wdata} !== {erdy, 2'd0, eb ? 8'h5C : 8'h00}) begin
                errors++;
                $display("FAIL single_out cyc%0d: rdy=%b tag=%0d data=%h, required rdy=%b tag=0 data=%h",
                         i, req_ready, fifo_wtag, fifo_wdata, erdy, eb ? 8'h5C : 8'h00);
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL single_drain: %0d beats outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_round_robin();
        logic eb;
        logic [1:0] et;
        logic [3:0] erdy;
        logic [7:0] edat;
        rdat = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        do_reset();
        for (int b = 0; b < 20; b++) begin
            et = 2'((b / 4) % 4);
            sb_q.push_back({et, rdat[et]});
        end
        for (int i = 0; i < 26; i++) begin
            tick(); apply((i < 25) ? 4'b1111 : 4'b0000, 1'b0, 1'b0);
            eb   = (i < 25) && (i % 5 != 0);
            et   = eb ? 2'((i / 5) % 4) : 2'd0;
            erdy = eb ? (4'b0001 << et) : 4'b0000;
            edat = eb ? rdat[et] : 8'h00;
            #2;
            vectors++;
            if (fifo_wr !== eb || busy !== eb) begin
                errors++;
                $display("FAIL rr_ctl cyc%0d: wr=%b busy=%b, required wr=%b busy=%b", i, fifo_wr, busy, eb, eb);
            end
            vectors++;
            if ({req_ready, fifo_wtag, fifo_wdata} !== {erdy, et, edat}) begin
                errors++;
                $display("FAIL rr_out cyc%0d: rdy=%b tag=%0d data=%h, required rdy=%b tag=%0d data=%h",
                         i, req_ready, fifo_wtag, fifo_wdata, erdy, et, edat);
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rr_drain: %0d beats outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_backpressure();
        logic f_c [9]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
        logic eb_c [9] = '{0, 1, 1, 1, 1, 1, 1, 1, 0};
        logic ew_c [9] = '{0, 1, 1, 0, 0, 0, 1, 1, 0};
        logic [3:0] erdy;
        logic [7:0] edat;
        rdat = '{8'h40, 8'hCC, 8'hDD, 8'hEE};
        do_reset();
        sb_q.push_back({2'd0, 8'h41});
        sb_q.push_back({2'd0, 8'h42});
        sb_q.push_back({2'd0, 8'h46});
        sb_q.push_back({2'd0, 8'h47});
        for (int i = 0; i < 9; i++) begin
            rdat[0] = 8'(8'h40 + i);
            tick(); apply((i < 8) ? 4'b0001 : 4'b0000, f_c[i], 1'b0);
            erdy = (eb_c[i] && !f_c[i]) ? 4'b0001 : 4'b0000;
            edat = eb_c[i] ? rdat[0] : 8'h00;
            #2;
            vectors++;
            if (fifo_wr !== ew_c[i] || busy !== eb_c[i]) begin
                errors++;
                $display("FAIL bp_ctl cyc%0d: wr=%b busy=%b, required wr=%b busy=%b", i, fifo_wr, busy, ew_c[i], eb_c[i]);
            end
            vectors++;
            if ({req_ready, fifo_wtag, fifo_wdata} !== {erdy, 2'd0, edat}) begin
                errors++;
                $display("FAIL bp_out cyc%0d: rdy=%b tag=%0d data=%h, required rdy=%b tag=0 data=%h",
                         i, req_ready, fifo_wtag, fifo_wdata, erdy, edat);
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL bp_drain: %0d beats outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_early_release();
        logic [3:0] v_c [9] = '{4'b0100, 4'b0100, 4'b1001, 4'b1001, 4'b1001,
                                4'b1001, 4'b1001, 4'b1001, 4'b0000};
        logic eb_c [9] = '{0, 1, 1, 0, 1, 1, 1, 1, 0};
        logic ew_c [9] = '{0, 1, 0, 0, 1, 1, 1, 1, 0};
        logic [1:0] et_c [9] = '{2, 2, 2, 0, 3, 3, 3, 3, 0};
        logic [3:0] erdy;
        logic [1:0] et;
        logic [7:0] edat;
        rdat = '{8'h0F, 8'h11, 8'h22, 8'h33};
        do_reset();
        sb_q.push_back({2'd2, 8'h22});
        for (int b = 0; b < 4; b++) sb_q.push_back({2'd3, 8'h33});
        for (int i = 0; i < 9; i++) begin
            tick(); apply(v_c[i], 1'b0, 1'b0);
            et   = eb_c[i] ? et_c[i] : 2'd0;
            erdy = eb_c[i] ? (4'b0001 << et) : 4'b0000;
            edat = eb_c[i] ? rdat[et] : 8'h00;
            #2;
            vectors++;
            if (fifo_wr !== ew_c[i] || busy !== eb_c[i]) begin
                errors++;
                $display("FAIL early_ctl cyc%0d: wr=%b busy=%b, required wr=%b busy=%b", i, fifo_wr, busy, ew_c[i], eb_c[i]);
            end
            vectors++;
            if ({req_ready, fifo_wtag, fifo_wdata} !== {erdy, et, edat}) begin
                errors++;
                $display("FAIL early_out cyc%0d: rdy=%b tag=%0d data=%h, required rdy=%b tag=%0d data=%h",
                         i, req_ready, fifo_wtag, fifo_wdata, erdy, et, edat);
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL early_drain: %0d beats outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [3:0] v_c [9] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0011,
                                4'b0011, 4'b0011, 4'b0011, 4'b0000};
        logic r_c [9]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0};
        logic eb_c [9] = '{0, 1, 1, 0, 1, 1, 1, 1, 0};
        logic [1:0] et_c [9] = '{1, 1, 1, 0, 0, 0, 0, 0, 0};
        logic [3:0] erdy;
        logic [1:0] et;
        logic [7:0] edat;
        rdat = '{8'h0F, 8'h11, 8'h22, 8'h33};
        do_reset();
        sb_q.push_back({2'd1, 8'h11});
        sb_q.push_back({2'd1, 8'h11});
        for (int b = 0; b < 4; b++) sb_q.push_back({2'd0, 8'h0F});
        for (int i = 0; i < 9; i++) begin
            tick(); apply(v_c[i], 1'b0, r_c[i]);
            et   = eb_c[i] ? et_c[i] : 2'd0;
            erdy = eb_c[i] ? (4'b0001 << et) : 4'b0000;
            edat = eb_c[i] ? rdat[et] : 8'h00;
            #2;
            vectors++;
            if (fifo_wr !== eb_c[i] || busy !== eb_c[i]) begin
                errors++;
                $display("FAIL rstmid_ctl cyc%0d: wr=%b busy=%b, required wr=%b busy=%b", i, fifo_wr, busy, eb_c[i], eb_c[i]);
            end
            vectors++;
            if ({req_ready, fifo_wtag, fifo_wdata} !== {erdy, et, edat}) begin
                errors++;
                $display("FAIL rstmid_out cyc%0d: rdy=%b tag=%0d data=%h, required rdy=%b tag=%0d data=%h",
                         i, req_ready, fifo_wtag, fifo_wdata, erdy, et, edat);
            end
        end
        @(negedge clk); #1;
        vectors++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_drain: %0d beats outstanding, required 0", sb_q.size());
            sb_q.delete();
        end
    endtask

    initial begin
        vectors   = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        rdat      = '{8'h00, 8'h00, 8'h00, 8'h00};
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_early_release();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
